// File: rtl/multicycle_controller_if.sv
// Control bundle between multicycle_controller and the CPU datapath.
// The illegal flag exists only when CTRL_ILLEGAL_TRAP_EN is defined.
interface multicycle_controller_if;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       alu_zero;
  logic       pc_we;
  logic       ir_we;
  logic       dr_we;
  logic       mem_we;
  logic       mem_addr_sel;
  logic       reg_we;
  logic [1:0] reg_aw_sel;
  logic [1:0] reg_dw_sel;
  logic       alu_src_sel;
  logic [2:0] alu_cmd;
  logic       branch_sel;
  logic [1:0] pc_sel;
  logic       instr_done;
  logic [3:0] state;
`ifdef CTRL_ILLEGAL_TRAP_EN
  logic       illegal;
`endif

  // No valid/ready pair here: instr_done is a one-cycle completion strobe in
  // each instruction's final cycle, and opcode/funct must stay stable from
  // DECODE until that strobe.
  modport master (
    input  opcode, funct, alu_zero,
    output pc_we, ir_we, dr_we, mem_we, mem_addr_sel, reg_we, reg_aw_sel,
           reg_dw_sel, alu_src_sel, alu_cmd, branch_sel, pc_sel, instr_done,
           state
`ifdef CTRL_ILLEGAL_TRAP_EN
    , output illegal
`endif
  );

  modport slave (
    output opcode, funct, alu_zero,
    input  pc_we, ir_we, dr_we, mem_we, mem_addr_sel, reg_we, reg_aw_sel,
           reg_dw_sel, alu_src_sel, alu_cmd, branch_sel, pc_sel, instr_done,
           state
`ifdef CTRL_ILLEGAL_TRAP_EN
    , input illegal
`endif
  );
endinterface

// File: rtl/multicycle_controller.sv
// FSM sequencing the shared-memory multicycle CPU datapath.
// CTRL_ILLEGAL_TRAP_EN: unknown instructions halt and raise illegal instead of acting as NOPs.
module multicycle_controller (
  input logic                     clk,
  input logic                     rst_n,
  multicycle_controller_if.master bus
);
  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_EXEC_R   = 4'd2,
    S_EXEC_I   = 4'd3,
    S_WB_ALU   = 4'd4,
    S_MEM_ADDR = 4'd5,
    S_MEM_RD   = 4'd6,
    S_MEM_WB   = 4'd7,
    S_MEM_WR   = 4'd8,
    S_BRANCH   = 4'd9,
    S_JUMP     = 4'd10,
    S_JAL      = 4'd11,
    S_JR       = 4'd12,
    S_NOP      = 4'd13,
    S_HALT     = 4'd15
  } state_t;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_XOR = 3'b010;
  localparam logic [2:0] ALU_SLT = 3'b011;

  state_t state_q, state_d;

  logic is_rtype, r_alu, r_jr, i_alu, op_lw, op_sw, op_bne, op_j, op_jal;
  logic [2:0] r_cmd, i_cmd;

  assign is_rtype = (bus.opcode == 6'h00);
  assign r_alu    = is_rtype && (bus.funct == 6'h20 || bus.funct == 6'h22 ||
                                 bus.funct == 6'h2A);
  assign r_jr     = is_rtype && (bus.funct == 6'h08);
  assign i_alu    = (bus.opcode == 6'h08) || (bus.opcode == 6'h0E);
  assign op_lw    = (bus.opcode == 6'h23);
  assign op_sw    = (bus.opcode == 6'h2B);
  assign op_bne   = (bus.opcode == 6'h05);
  assign op_j     = (bus.opcode == 6'h02);
  assign op_jal   = (bus.opcode == 6'h03);
  assign r_cmd    = (bus.funct == 6'h22) ? ALU_SUB :
                    (bus.funct == 6'h2A) ? ALU_SLT : ALU_ADD;
  assign i_cmd    = (bus.opcode == 6'h0E) ? ALU_XOR : ALU_ADD;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  logic       pc_we_c, ir_we_c, dr_we_c, mem_we_c, mem_addr_sel_c, reg_we_c;
  logic [1:0] reg_aw_sel_c, reg_dw_sel_c, pc_sel_c;
  logic       alu_src_sel_c, branch_sel_c, instr_done_c;
  logic [2:0] alu_cmd_c;

  always_comb begin
    state_d        = state_q;
    pc_we_c        = 1'b0;
    ir_we_c        = 1'b0;
    dr_we_c        = 1'b0;
    mem_we_c       = 1'b0;
    mem_addr_sel_c = 1'b0;
    reg_we_c       = 1'b0;
    reg_aw_sel_c   = 2'd0;
    reg_dw_sel_c   = 2'd0;
    pc_sel_c       = 2'd0;
    alu_src_sel_c  = 1'b0;
    branch_sel_c   = 1'b0;
    instr_done_c   = 1'b0;
    alu_cmd_c      = ALU_ADD;
    case (state_q)
      S_FETCH: begin
        ir_we_c = 1'b1;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        if      (r_alu)          state_d = S_EXEC_R;
        else if (r_jr)           state_d = S_JR;
        else if (i_alu)          state_d = S_EXEC_I;
        else if (op_lw || op_sw) state_d = S_MEM_ADDR;
        else if (op_bne)         state_d = S_BRANCH;
        else if (op_j)           state_d = S_JUMP;
        else if (op_jal)         state_d = S_JAL;
`ifdef CTRL_ILLEGAL_TRAP_EN
        else                     state_d = S_HALT;
`else
        else                     state_d = S_NOP;
`endif
      end
      S_EXEC_R: begin
        alu_cmd_c = r_cmd;
        state_d   = S_WB_ALU;
      end
      S_EXEC_I: begin
        alu_src_sel_c = 1'b1;
        alu_cmd_c     = i_cmd;
        state_d       = S_WB_ALU;
      end
      // ALU controls stay on so the result is still valid at the write.
      S_WB_ALU: begin
        alu_src_sel_c = !is_rtype;
        alu_cmd_c     = is_rtype ? r_cmd : i_cmd;
        reg_we_c      = 1'b1;
        reg_aw_sel_c  = is_rtype ? 2'd0 : 2'd1;
        pc_we_c       = 1'b1;
        instr_done_c  = 1'b1;
        state_d       = S_FETCH;
      end
      S_MEM_ADDR: begin
        alu_src_sel_c = 1'b1;
        state_d       = op_sw ? S_MEM_WR : S_MEM_RD;
      end
      S_MEM_RD: begin
        alu_src_sel_c  = 1'b1;
        mem_addr_sel_c = 1'b1;
        dr_we_c        = 1'b1;
        state_d        = S_MEM_WB;
      end
      S_MEM_WB: begin
        mem_addr_sel_c = 1'b1;
        reg_we_c       = 1'b1;
        reg_aw_sel_c   = 2'd1;
        reg_dw_sel_c   = 2'd1;
        pc_we_c        = 1'b1;
        instr_done_c   = 1'b1;
        state_d        = S_FETCH;
      end
      S_MEM_WR: begin
        alu_src_sel_c  = 1'b1;
        mem_addr_sel_c = 1'b1;
        mem_we_c       = 1'b1;
        pc_we_c        = 1'b1;
        instr_done_c   = 1'b1;
        state_d        = S_FETCH;
      end
      S_BRANCH: begin
        alu_cmd_c    = ALU_SUB;
        branch_sel_c = !bus.alu_zero;
        pc_we_c      = 1'b1;
        instr_done_c = 1'b1;
        state_d      = S_FETCH;
      end
      S_JUMP: begin
        pc_sel_c     = 2'd1;
        pc_we_c      = 1'b1;
        instr_done_c = 1'b1;
        state_d      = S_FETCH;
      end
      S_JAL: begin
        reg_we_c     = 1'b1;
        reg_aw_sel_c = 2'd2;
        reg_dw_sel_c = 2'd2;
        pc_sel_c     = 2'd1;
        pc_we_c      = 1'b1;
        instr_done_c = 1'b1;
        state_d      = S_FETCH;
      end
      S_JR: begin
        pc_sel_c     = 2'd2;
        pc_we_c      = 1'b1;
        instr_done_c = 1'b1;
        state_d      = S_FETCH;
      end
      S_NOP: begin
        pc_we_c      = 1'b1;
        instr_done_c = 1'b1;
        state_d      = S_FETCH;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase
  end

  // Reset masks every output combinationally so nothing fires while rst_n is low.
  assign bus.pc_we        = rst_n & pc_we_c;
  assign bus.ir_we        = rst_n & ir_we_c;
  assign bus.dr_we        = rst_n & dr_we_c;
  assign bus.mem_we       = rst_n & mem_we_c;
  assign bus.mem_addr_sel = rst_n & mem_addr_sel_c;
  assign bus.reg_we       = rst_n & reg_we_c;
  assign bus.reg_aw_sel   = rst_n ? reg_aw_sel_c : 2'd0;
  assign bus.reg_dw_sel   = rst_n ? reg_dw_sel_c : 2'd0;
  assign bus.alu_src_sel  = rst_n & alu_src_sel_c;
  assign bus.alu_cmd      = rst_n ? alu_cmd_c : 3'd0;
  assign bus.branch_sel   = rst_n & branch_sel_c;
  assign bus.pc_sel       = rst_n ? pc_sel_c : 2'd0;
  assign bus.instr_done   = rst_n & instr_done_c;
  assign bus.state        = rst_n ? state_q : S_FETCH;
`ifdef CTRL_ILLEGAL_TRAP_EN
  assign bus.illegal      = rst_n & (state_q == S_HALT);
`endif
endmodule

// File: tb/tb_multicycle_controller.sv
// Randomized scoreboard bench for multicycle_controller: per-cycle expected
// control vectors are queued by the driver and compared by a negedge monitor.
module tb_multicycle_controller;
  typedef struct packed {
    logic       illegal;
    logic       pc_we;
    logic       ir_we;
    logic       dr_we;
    logic       mem_we;
    logic       mem_addr_sel;
    logic       reg_we;
    logic [1:0] reg_aw_sel;
    logic [1:0] reg_dw_sel;
    logic       alu_src_sel;
    logic [2:0] alu_cmd;
    logic       branch_sel;
    logic [1:0] pc_sel;
    logic       instr_done;
    logic [3:0] state;
  } rec_t;
  localparam int W = $bits(rec_t);
  localparam int HALT_CYCLES = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  multicycle_controller_if bus ();
  multicycle_controller dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  logic [W-1:0] exp_q[$];
  rec_t         seq[$];
  int           checks = 0;
  int           errors = 0;
  int           done_seen = 0;

  function automatic rec_t sample();
    rec_t r;
    r              = '0;
    r.pc_we        = bus.pc_we;
    r.ir_we        = bus.ir_we;
    r.dr_we        = bus.dr_we;
    r.mem_we       = bus.mem_we;
    r.mem_addr_sel = bus.mem_addr_sel;
    r.reg_we       = bus.reg_we;
    r.reg_aw_sel   = bus.reg_aw_sel;
    r.reg_dw_sel   = bus.reg_dw_sel;
    r.alu_src_sel  = bus.alu_src_sel;
    r.alu_cmd      = bus.alu_cmd;
    r.branch_sel   = bus.branch_sel;
    r.pc_sel       = bus.pc_sel;
    r.instr_done   = bus.instr_done;
    r.state        = bus.state;
`ifdef CTRL_ILLEGAL_TRAP_EN
    r.illegal      = bus.illegal;
`endif
    return r;
  endfunction

  // Monitor: every negedge with a pending expectation is one comparison.
  always @(negedge clk) begin
    if (bus.instr_done === 1'b1) done_seen++;
    if (exp_q.size() > 0) begin
      rec_t e, g;
      e = rec_t'(exp_q.pop_front());
      g = sample();
      checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL ctrl_cycle t=%0t state got %0d exp %0d, outputs got %h exp %h",
                 $time, g.state, e.state, g, e);
      end
    end
  end

  // Reference model: instruction class -> list of per-cycle control vectors.
  task automatic build(input logic [5:0] op, input logic [5:0] fn, input logic z);
    rec_t r, fin;
    logic [2:0] cmd;
    seq.delete();
    r = '0; r.ir_we = 1'b1; r.state = 4'd0; seq.push_back(r);
    r = '0; r.state = 4'd1; seq.push_back(r);
    fin = '0; fin.pc_we = 1'b1; fin.instr_done = 1'b1;
    if (op == 6'h00 && (fn == 6'h20 || fn == 6'h22 || fn == 6'h2A)) begin
      cmd = (fn == 6'h22) ? 3'b001 : (fn == 6'h2A) ? 3'b011 : 3'b000;
      r = '0; r.alu_cmd = cmd; r.state = 4'd2; seq.push_back(r);
      r = fin; r.alu_cmd = cmd; r.reg_we = 1'b1; r.state = 4'd4; seq.push_back(r);
    end else if (op == 6'h08 || op == 6'h0E) begin
      cmd = (op == 6'h0E) ? 3'b010 : 3'b000;
      r = '0; r.alu_src_sel = 1'b1; r.alu_cmd = cmd; r.state = 4'd3; seq.push_back(r);
      r = fin; r.alu_src_sel = 1'b1; r.alu_cmd = cmd; r.reg_we = 1'b1;
      r.reg_aw_sel = 2'd1; r.state = 4'd4; seq.push_back(r);
    end else if (op == 6'h23) begin
      r = '0; r.alu_src_sel = 1'b1; r.state = 4'd5; seq.push_back(r);
      r = '0; r.alu_src_sel = 1'b1; r.mem_addr_sel = 1'b1; r.dr_we = 1'b1;
      r.state = 4'd6; seq.push_back(r);
      r = fin; r.mem_addr_sel = 1'b1; r.reg_we = 1'b1; r.reg_aw_sel = 2'd1;
      r.reg_dw_sel = 2'd1; r.state = 4'd7; seq.push_back(r);
    end else if (op == 6'h2B) begin
      r = '0; r.alu_src_sel = 1'b1; r.state = 4'd5; seq.push_back(r);
      r = fin; r.alu_src_sel = 1'b1; r.mem_addr_sel = 1'b1; r.mem_we = 1'b1;
      r.state = 4'd8; seq.push_back(r);
    end else if (op == 6'h05) begin
      r = fin; r.alu_cmd = 3'b001; r.branch_sel = ~z; r.state = 4'd9; seq.push_back(r);
    end else if (op == 6'h02) begin
      r = fin; r.pc_sel = 2'd1; r.state = 4'd10; seq.push_back(r);
    end else if (op == 6'h03) begin
      r = fin; r.reg_we = 1'b1; r.reg_aw_sel = 2'd2; r.reg_dw_sel = 2'd2;
      r.pc_sel = 2'd1; r.state = 4'd11; seq.push_back(r);
    end else if (op == 6'h00 && fn == 6'h08) begin
      r = fin; r.pc_sel = 2'd2; r.state = 4'd12; seq.push_back(r);
    end else begin
`ifdef CTRL_ILLEGAL_TRAP_EN
      for (int i = 0; i < HALT_CYCLES; i++) begin
        r = '0; r.illegal = 1'b1; r.state = 4'd15; seq.push_back(r);
      end
`else
      r = fin; r.state = 4'd13; seq.push_back(r);
`endif
    end
  endtask

  // Driver tasks: each starts and ends 1 time unit after a rising edge.
  task automatic do_reset(input int cycles);
    rec_t g;
    rst_n = 1'b0;
    for (int i = 0; i < cycles; i++) exp_q.push_back('0);
    #1;
    g = sample();
    checks++;
    if (g !== rec_t'('0)) begin
      errors++;
      $display("FAIL reset_state t=%0t state got %0d exp 0, outputs got %h exp 0",
               $time, g.state, g);
    end
    @(posedge clk); #1;
    repeat (cycles - 1) begin @(posedge clk); #1; end
    rst_n = 1'b1;
  endtask

  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn,
                           input logic z, input int cut);
    int n;
    int done_before;
    build(op, fn, z);
    n = (cut < seq.size()) ? cut : seq.size();
    bus.opcode   = op;
    bus.funct    = fn;
    bus.alu_zero = z;
    done_before  = done_seen;
    for (int i = 0; i < n; i++) exp_q.push_back(seq[i]);
    repeat (n) begin @(posedge clk); #1; end
    if (n == seq.size() && seq[n-1].state != 4'd15) begin
      checks++;
      if (done_seen - done_before != 1) begin
        errors++;
        $display("FAIL instr_done_wait t=%0t op %h fn %h: wait of %0d cycles expired with %0d pulses, exp 1",
                 $time, op, fn, n, done_seen - done_before);
      end
    end
    if (n < seq.size() || seq[n-1].state == 4'd15) do_reset(2);
  endtask

  logic [5:0] op_tab [14];
  logic [5:0] fn_tab [14];

  initial begin
    op_tab = '{6'h00, 6'h00, 6'h00, 6'h00, 6'h08, 6'h0E, 6'h23, 6'h2B,
               6'h05, 6'h02, 6'h03, 6'h3F, 6'h00, 6'h11};
    fn_tab = '{6'h20, 6'h22, 6'h2A, 6'h08, 6'h01, 6'h3F, 6'h05, 6'h10,
               6'h00, 6'h00, 6'h00, 6'h00, 6'h21, 6'h20};
    bus.opcode   = 6'h00;
    bus.funct    = 6'h00;
    bus.alu_zero = 1'b0;
    @(posedge clk); #1;
    do_reset(3);
    // Directed: the main instruction classes and the branch/illegal corners.
    run_instr(6'h00, 6'h20, 1'b0, 99);   // ADD
    run_instr(6'h23, 6'h00, 1'b0, 99);   // LW
    run_instr(6'h05, 6'h00, 1'b0, 99);   // BNE taken
    run_instr(6'h05, 6'h00, 1'b1, 99);   // BNE not taken
    run_instr(6'h03, 6'h00, 1'b0, 99);   // JAL
    run_instr(6'h00, 6'h08, 1'b0, 99);   // JR
    run_instr(6'h2B, 6'h00, 1'b1, 99);   // SW
    run_instr(6'h08, 6'h00, 1'b0, 99);   // ADDI
    run_instr(6'h0E, 6'h00, 1'b0, 99);   // XORI
    run_instr(6'h00, 6'h22, 1'b0, 99);   // SUB
    run_instr(6'h00, 6'h2A, 1'b0, 99);   // SLT
    run_instr(6'h3F, 6'h00, 1'b0, 99);   // illegal opcode
    run_instr(6'h00, 6'h21, 1'b0, 99);   // unknown R-type funct
    run_instr(6'h23, 6'h00, 1'b0, 3);    // LW abandoned by reset
    run_instr(6'h2B, 6'h00, 1'b0, 2);    // SW abandoned before its write
    run_instr(6'h02, 6'h00, 1'b0, 99);   // J
    for (int k = 0; k < 150; k++) begin
      int sel;
      logic [5:0] op, fn;
      sel = $urandom_range(0, 16);
      if (sel < 14) begin
        op = op_tab[sel];
        fn = fn_tab[sel];
      end else begin
        op = 6'($urandom_range(0, 63));
        fn = 6'($urandom_range(0, 63));
      end
      run_instr(op, fn, 1'($urandom_range(0, 1)),
                ($urandom_range(0, 19) == 0) ? $urandom_range(1, 4) : 99);
    end
    @(posedge clk); #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
